cache_fsm_l2a: RTL and testbench

- Private level-2 cache controller for processor a; sits directly downstream of the L1a controller and upstream of main memory.
- Services L1a block fills, inclusive word writes (write-through from L1a hits) and dirty-block write-backs from L1a.
- 2-way set-associative, write-back/write-allocate, 1-bit LRU per set; fetches and evicts whole blocks over a single-ack memory handshake.

---
 rtl/cache_config.sv | 45 ++++
 rtl/main_memory_config.sv | 8 +
 rtl/cache_L2a_tag_array.sv | 89 ++++++++
 rtl/cache_fsm_l2a.sv | 232 +++++++++++++++++++++++
 tb/tb_cache_fsm_l2a.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_config.sv
// Cache controller configuration: L2 geometry, FSM states and ops.
// Address layout: pid | tag | index | offset (LSBs).
package cache_config;
  import main_memory_config::*;

  localparam int ADDR_W       = 16;
  localparam int PID_W        = 2;
  localparam int L2_SETS      = 16;
  localparam int L2_WAYS      = 2;
  localparam int L2_INDEX_W   = 4;
  localparam int L2_TAG_W     = ADDR_W - PID_W
                              - L2_INDEX_W - OFFSET_W;
  localparam int L2_INDEX_LSB = OFFSET_W;
  localparam int L2_TAG_LSB   = OFFSET_W + L2_INDEX_W;
  localparam int PID_LSB      = ADDR_W - PID_W;

  typedef logic [L2_TAG_W-1:0]   l2_tag_t;
  typedef logic [L2_INDEX_W-1:0] l2_index_t;
  typedef logic [BLOCK_W-1:0]    block_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVICT,
    FILL,
    RESPOND
  } l2_state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_WB
  } l2_op_t;

  function automatic block_t merge_word(
    input block_t                blk,
    input logic [WORD_W-1:0]     w,
    input logic [OFFSET_W-1:0]   off
  );
    block_t r;
    r = blk;
    r[off*WORD_W +: WORD_W] = w;
    return r;
  endfunction
endpackage

// File: rtl/main_memory_config.sv
// Main memory geometry shared by every cache level.
// A block is BLOCK_WORDS words; word 0 sits in the LSBs.
package main_memory_config;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 2;
  localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;
endpackage

// File: rtl/cache_L2a_tag_array.sv
// L2a storage: valid/dirty/tag/data per way, 1-bit LRU per set.
// Combinational 2-way compare and victim choice on the given index.
module cache_L2a_tag_array
  import main_memory_config::*;
  import cache_config::*;
(
  input  logic      clk,
  input  logic      reset,
  input  l2_index_t index,
  input  l2_tag_t   tag,
  input  logic      rd_way,
  output logic      hit,
  output logic      hit_way,
  output logic      victim_way,
  output logic      victim_dirty,
  output logic      rd_valid,
  output logic      rd_dirty,
  output l2_tag_t   rd_tag,
  output block_t    rd_data,
  input  logic      wr_en,
  input  logic      wr_way,
  input  logic      wr_valid,
  input  logic      wr_dirty,
  input  l2_tag_t   wr_tag,
  input  block_t    wr_data,
  input  logic      lru_we,
  input  logic      lru_val
);

  logic [L2_WAYS-1:0] valid_q [L2_SETS];
  logic [L2_WAYS-1:0] dirty_q [L2_SETS];
  l2_tag_t            tag_q   [L2_WAYS][L2_SETS];
  block_t             data_q  [L2_WAYS][L2_SETS];
  logic [L2_SETS-1:0] lru_q;

  logic [L2_WAYS-1:0] match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < L2_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[index][wr_way] <= wr_valid;
        dirty_q[index][wr_way] <= wr_dirty;
      end
      if (lru_we) begin
        lru_q[index] <= lru_val;
      end
    end
  end

  // Tag and data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][index]  <= wr_tag;
      data_q[wr_way][index] <= wr_data;
    end
  end

  assign match[0] = valid_q[index][0]
                 && (tag_q[0][index] == tag);
  assign match[1] = valid_q[index][1]
                 && (tag_q[1][index] == tag);

  assign hit     = |match;
  assign hit_way = ~match[0];

  always_comb begin
    victim_way = lru_q[index];
    if (!valid_q[index][0]) begin
      victim_way = 1'b0;
    end else if (!valid_q[index][1]) begin
      victim_way = 1'b1;
    end
  end

  assign victim_dirty = valid_q[index][victim_way]
                     && dirty_q[index][victim_way];

  assign rd_valid = valid_q[index][rd_way];
  assign rd_dirty = dirty_q[index][rd_way];
  assign rd_tag   = tag_q[rd_way][index];
  assign rd_data  = data_q[rd_way][index];

endmodule

// File: rtl/cache_fsm_l2a.sv
// Private L2 controller for processor a: 2-way, write-back,
// write-allocate, whole-block fetch/evict over a single-ack memory port.
module cache_fsm_l2a
  import main_memory_config::*;
  import cache_config::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               l1_read_req,
  input  logic               l1_write_req,
  input  logic               l1_wb_req,
  input  logic [ADDR_W-1:0]  l1_addr,
  input  logic [WORD_W-1:0]  l1_wdata,
  input  logic [BLOCK_W-1:0] l1_wb_data,
  output logic [BLOCK_W-1:0] l1_rdata,
  output logic               l1_ready,
  output logic               l1_write_ack,
  output logic               l1_wb_ack,
  output logic               mem_read_req,
  output logic               mem_write_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);

  l2_state_t          state_q;
  l2_state_t          state_d;
  l2_op_t             op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  block_t             wb_q;
  logic               way_q;
  logic               any_req;

  l2_index_t idx;
  l2_tag_t   tag;
  logic      hit;
  logic      hit_way;
  logic      victim_way;
  logic      victim_dirty;
  logic      rd_valid;
  logic      rd_dirty;
  l2_tag_t   rd_tag;
  block_t    rd_data;

  logic      wr_en;
  logic      wr_valid;
  logic      wr_dirty;
  l2_tag_t   wr_tag;
  block_t    wr_data;
  logic      lru_we;
  logic      lru_val;

  assign any_req = l1_read_req | l1_write_req | l1_wb_req;
  assign idx     = addr_q[L2_INDEX_LSB +: L2_INDEX_W];
  assign tag     = addr_q[L2_TAG_LSB +: L2_TAG_W];

  cache_L2a_tag_array u_tags (
    .clk          (clk),
    .reset        (reset),
    .index        (idx),
    .tag          (tag),
    .rd_way       (way_q),
    .hit          (hit),
    .hit_way      (hit_way),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_way       (way_q),
    .wr_valid     (wr_valid),
    .wr_dirty     (wr_dirty),
    .wr_tag       (wr_tag),
    .wr_data      (wr_data),
    .lru_we       (lru_we),
    .lru_val      (lru_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_q       <= '0;
      way_q      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        addr_q  <= l1_addr;
        wdata_q <= l1_wdata;
        wb_q    <= l1_wb_data;
        if (l1_wb_req) begin
          op_q <= OP_WB;
        end else if (l1_write_req) begin
          op_q <= OP_WRITE;
        end else begin
          op_q <= OP_READ;
        end
      end
      if (state_q == LOOKUP) begin
        way_q <= hit ? hit_way : victim_way;
        if (hit) begin
          if (hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
          end
        end else if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          state_d = RESPOND;
        end else if (victim_dirty) begin
          state_d = EVICT;
        end else if (op_q == OP_WB) begin
          state_d = RESPOND;
        end else begin
          state_d = FILL;
        end
      end
      EVICT: begin
        if (mem_ready) begin
          state_d = (op_q == OP_WB) ? RESPOND : FILL;
        end
      end
      FILL: begin
        if (mem_ready) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array write port defaults to rewriting the selected line unchanged.
  always_comb begin
    l1_rdata      = '0;
    l1_ready      = 1'b0;
    l1_write_ack  = 1'b0;
    l1_wb_ack     = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wr_en         = 1'b0;
    wr_valid      = rd_valid;
    wr_dirty      = rd_dirty;
    wr_tag        = rd_tag;
    wr_data       = rd_data;
    lru_we        = 1'b0;
    lru_val       = ~way_q;
    unique case (state_q)
      EVICT: begin
        mem_write_req = 1'b1;
        mem_addr      = {addr_q[PID_LSB +: PID_W], rd_tag,
                         idx, {OFFSET_W{1'b0}}};
        mem_wdata     = rd_data;
        if (mem_ready) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
        end
      end
      FILL: begin
        mem_read_req = 1'b1;
        mem_addr     = {addr_q[ADDR_W-1:OFFSET_W],
                        {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag   = tag;
          wr_data  = mem_rdata;
        end
      end
      RESPOND: begin
        lru_we = 1'b1;
        unique case (op_q)
          OP_READ: begin
            l1_ready = 1'b1;
            l1_rdata = rd_data;
          end
          OP_WRITE: begin
            l1_write_ack = 1'b1;
            wr_en        = 1'b1;
            wr_valid     = 1'b1;
            wr_dirty     = 1'b1;
            wr_tag       = tag;
            wr_data      = merge_word(rd_data, wdata_q,
                                      addr_q[OFFSET_W-1:0]);
          end
          OP_WB: begin
            l1_wb_ack = 1'b1;
            wr_en     = 1'b1;
            wr_valid  = 1'b1;
            wr_dirty  = 1'b1;
            wr_tag    = tag;
            wr_data   = wb_q;
          end
          default: begin
            lru_we = 1'b0;
          end
        endcase
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fsm_l2a.sv
// Directed scoreboard bench for cache_fsm_l2a: memory model plus
// queues of expected memory transactions and L1 acknowledgements.
module tb_cache_fsm_l2a;

  logic         clk;
  logic         reset;
  logic         l1_read_req;
  logic         l1_write_req;
  logic         l1_wb_req;
  logic [15:0]  l1_addr;
  logic [31:0]  l1_wdata;
  logic [127:0] l1_wb_data;
  logic [127:0] l1_rdata;
  logic         l1_ready;
  logic         l1_write_ack;
  logic         l1_wb_ack;
  logic         mem_read_req;
  logic         mem_write_req;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  cache_fsm_l2a dut (
    .clk           (clk),
    .reset         (reset),
    .l1_read_req   (l1_read_req),
    .l1_write_req  (l1_write_req),
    .l1_wb_req     (l1_wb_req),
    .l1_addr       (l1_addr),
    .l1_wdata      (l1_wdata),
    .l1_wb_data    (l1_wb_data),
    .l1_rdata      (l1_rdata),
    .l1_ready      (l1_ready),
    .l1_write_ack  (l1_write_ack),
    .l1_wb_ack     (l1_wb_ack),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } mem_exp_t;

  typedef struct {
    int           kind;
    logic [127:0] data;
  } l1_exp_t;

  mem_exp_t mem_q[$];
  l1_exp_t  l1_q[$];
  mem_exp_t me;
  l1_exp_t  le;

  int n_chk;
  int n_fail;
  int mem_delay;
  int mem_cnt;
  bit mem_busy;

  localparam logic [127:0] B1  = {32'h44444444, 32'h33333333,
                                  32'h22222222, 32'h11111111};
  localparam logic [127:0] B1M = {32'h44444444, 32'hDEADBEEF,
                                  32'h22222222, 32'h11111111};
  localparam logic [127:0] B5  = {32'h55550003, 32'h55550002,
                                  32'h55550001, 32'h55550000};
  localparam logic [127:0] B9  = {32'h99990003, 32'h99990002,
                                  32'h99990001, 32'h99990000};
  localparam logic [127:0] BW  = {32'hAAAA0003, 32'hAAAA0002,
                                  32'hAAAA0001, 32'hAAAA0000};
  localparam logic [127:0] B3A = {32'h30300003, 32'h30300002,
                                  32'h30300001, 32'h30300000};
  localparam logic [127:0] B3B = {32'h3B3B0003, 32'h3B3B0002,
                                  32'h3B3B0001, 32'h3B3B0000};

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int kind);
    if (kind == 0) return l1_ready;
    if (kind == 1) return l1_write_ack;
    return l1_wb_ack;
  endfunction

  function automatic logic [2:0] ack_vec(input int kind);
    if (kind == 0) return 3'b100;
    if (kind == 1) return 3'b010;
    return 3'b001;
  endfunction

  // Memory model: accepts a request, pulses mem_ready mem_delay
  // negedges later, and checks every request against mem_q.
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      mem_busy  = 1'b0;
    end else begin
      chk("mem_exclusive",
          128'(mem_read_req & mem_write_req), 128'(0));
      if (mem_ready) mem_ready = 1'b0;
      if (mem_busy) begin
        mem_cnt++;
        if (mem_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          mem_busy  = 1'b0;
        end
      end else if (mem_read_req || mem_write_req) begin
        chk("mem_expected", 128'(mem_q.size() != 0), 128'(1));
        if (mem_q.size() != 0) begin
          me = mem_q.pop_front();
          chk("mem_kind", 128'(mem_write_req), 128'(me.wr));
          chk("mem_addr", 128'(mem_addr), 128'(me.addr));
          if (me.wr) chk("mem_wdata", mem_wdata, me.data);
          else       mem_rdata = me.data;
        end
        mem_busy = 1'b1;
        mem_cnt  = 1;
      end
    end
  end

  // L1 acknowledgement monitor.
  always @(negedge clk) begin
    if (!reset && (l1_ready | l1_write_ack | l1_wb_ack)) begin
      chk("l1_expected", 128'(l1_q.size() != 0), 128'(1));
      if (l1_q.size() != 0) begin
        le = l1_q.pop_front();
        chk("l1_ack_kind",
            128'({l1_ready, l1_write_ack, l1_wb_ack}),
            128'(ack_vec(le.kind)));
        if (le.kind == 0) chk("l1_rdata", l1_rdata, le.data);
      end
    end
  end

  task automatic wait_ack(input int kind, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_of(kind) && cyc < 200);
    chk("ack_seen", 128'(ack_of(kind)), 128'(1));
  endtask

  task automatic l1_op(input int kind, input logic [15:0] a,
                       input logic [31:0] w,
                       input logic [127:0] wb,
                       input logic [127:0] exp_rd,
                       input int exp_lat);
    int cyc;
    l1_exp_t e;
    @(negedge clk);
    l1_addr    = a;
    l1_wdata   = w;
    l1_wb_data = wb;
    e.kind = kind;
    e.data = exp_rd;
    l1_q.push_back(e);
    if (kind == 0) l1_read_req  = 1'b1;
    if (kind == 1) l1_write_req = 1'b1;
    if (kind == 2) l1_wb_req    = 1'b1;
    wait_ack(kind, cyc);
    chk("latency", 128'(cyc), 128'(exp_lat));
    l1_read_req  = 1'b0;
    l1_write_req = 1'b0;
    l1_wb_req    = 1'b0;
  endtask

  task automatic exp_mem(input bit wr, input logic [15:0] a,
                         input logic [127:0] d);
    mem_exp_t e;
    e.wr   = wr;
    e.addr = a;
    e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic chk_counts(input logic [15:0] h,
                            input logic [15:0] m);
    chk("hit_count", 128'(hit_count), 128'(h));
    chk("miss_count", 128'(miss_count), 128'(m));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 128'({l1_ready, l1_write_ack, l1_wb_ack,
                   mem_read_req, mem_write_req, mem_addr,
                   hit_count, miss_count}), 128'(0));
    chk({tag, "_rdata"}, l1_rdata, 128'(0));
    chk({tag, "_wdata"}, mem_wdata, 128'(0));
  endtask

  initial begin
    int cyc;
    l1_exp_t e;
    n_chk        = 0;
    n_fail       = 0;
    mem_delay    = 3;
    mem_cnt      = 0;
    mem_busy     = 1'b0;
    reset        = 1'b1;
    l1_read_req  = 1'b0;
    l1_write_req = 1'b0;
    l1_wb_req    = 1'b0;
    l1_addr      = '0;
    l1_wdata     = '0;
    l1_wb_data   = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;

    // cold read miss, then hit
    exp_mem(1'b0, 16'h0010, B1);
    l1_op(0, 16'h0010, 32'h0, 128'h0, B1, 5);
    chk_counts(16'd0, 16'd1);
    l1_op(0, 16'h0010, 32'h0, 128'h0, B1, 2);
    chk_counts(16'd1, 16'd1);

    // word write hit and read-back
    l1_op(1, 16'h0012, 32'hDEADBEEF, 128'h0, 128'h0, 2);
    l1_op(0, 16'h0010, 32'h0, 128'h0, B1M, 2);
    chk_counts(16'd3, 16'd1);

    // fill second way, then evict dirty way0
    exp_mem(1'b0, 16'h0050, B5);
    l1_op(0, 16'h0050, 32'h0, 128'h0, B5, 5);
    exp_mem(1'b1, 16'h0010, B1M);
    exp_mem(1'b0, 16'h0090, B9);
    l1_op(0, 16'h0090, 32'h0, 128'h0, B9, 8);
    chk_counts(16'd3, 16'd3);
    l1_op(0, 16'h0050, 32'h0, 128'h0, B5, 2);
    chk_counts(16'd4, 16'd3);

    // simultaneous wb and read: wb first, read hits after
    @(negedge clk);
    l1_addr    = 16'h0020;
    l1_wb_data = BW;
    e.kind = 2; e.data = 128'h0;
    l1_q.push_back(e);
    e.kind = 0; e.data = BW;
    l1_q.push_back(e);
    l1_wb_req   = 1'b1;
    l1_read_req = 1'b1;
    wait_ack(2, cyc);
    chk("wb_latency", 128'(cyc), 128'(2));
    l1_wb_req = 1'b0;
    wait_ack(0, cyc);
    chk("rd_after_wb_latency", 128'(cyc), 128'(3));
    l1_read_req = 1'b0;
    chk_counts(16'd5, 16'd4);

    // reset while waiting in FILL
    mem_delay = 20;
    exp_mem(1'b0, 16'h0030, B3A);
    @(negedge clk);
    l1_addr     = 16'h0030;
    l1_read_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("fill_pending", 128'({mem_read_req, mem_write_req}),
        128'(2'b10));
    chk("fill_addr", 128'(mem_addr), 128'(16'h0030));
    reset       = 1'b1;
    l1_read_req = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");
    reset     = 1'b0;
    mem_delay = 3;
    exp_mem(1'b0, 16'h0030, B3B);
    l1_op(0, 16'h0030, 32'h0, 128'h0, B3B, 5);
    chk_counts(16'd0, 16'd1);

    repeat (3) @(negedge clk);
    chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
    chk("l1_q_drained", 128'(l1_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
